// File: rtl/activation_serializer.sv
// activation_serializer
// Captures one EngineCount-wide vector of activated values in a single cycle
// and streams lanes 0..n-1 out one per cycle over a valid/ready handshake.
// Back-to-back vectors stream without bubbles when the next load arrives in
// the cycle of the current vector's last transfer.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   load_i         capture request for value_i / active_count_i
//   value_i        lane vector from the activation layer (EngineCount x Bits)
//   active_count_i number of lanes to emit, starting at lane 0 (clamped)
//   ready_o        block accepts a load this cycle (combinational from ready_i)
//   value_o        current streamed value
//   valid_o        value_o / last_o are valid
//   last_o         value_o is the final lane of the current vector
//   ready_i        downstream accepts value_o this cycle
//   busy_o         a vector is held and not fully emitted
module activation_serializer #(
    parameter int unsigned Bits        = 16,
    parameter logic [11:0] EngineCount = 12'd8
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   load_i,
    input  logic [EngineCount-1:0][Bits-1:0]       value_i,
    input  logic [11:0]                            active_count_i,
    output logic                                   ready_o,
    output logic signed [Bits-1:0]                 value_o,
    output logic                                   valid_o,
    output logic                                   last_o,
    input  logic                                   ready_i,
    output logic                                   busy_o
);

    localparam int unsigned Lanes = int'(EngineCount);
    localparam int unsigned IdxW  = (Lanes > 1) ? $clog2(Lanes) : 1;
    localparam int unsigned CntW  = 12;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                       state_q;
    state_t                       state_d;
    logic [IdxW-1:0]              idx_q;
    logic [IdxW-1:0]              idx_d;
    logic [IdxW-1:0]              idx_inc;
    logic [CntW-1:0]              count_q;
    logic [CntW-1:0]              count_d;
    logic [Lanes-1:0][Bits-1:0]   buf_q;
    logic [Lanes-1:0][Bits-1:0]   buf_d;
    logic [Bits-1:0]              value_d;
    logic                         valid_d;
    logic                         last_d;

    logic                         xfer;
    logic                         accept;
    logic                         start;
    logic [CntW-1:0]              n_in;

    // Handshake decode; ready_o is the only path from ready_i to an output.
    assign xfer    = valid_o & ready_i;
    assign ready_o = (state_q == IDLE) | (xfer & last_o);
    assign accept  = load_i & ready_o;
    assign n_in    = (active_count_i > EngineCount) ? EngineCount : active_count_i;
    // A zero-length load is accepted but produces nothing.
    assign start   = accept & (n_in != CntW'(0));
    assign idx_inc = idx_q + IdxW'(1);
    assign busy_o  = (state_q == SEND);

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (xfer && last_o) begin
                    state_d = start ? SEND : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        idx_d   = idx_q;
        count_d = count_q;
        buf_d   = buf_q;
        value_d = value_o;
        valid_d = valid_o;
        last_d  = last_o;
        if (start) begin
            // New vector (also covers the no-bubble reload on the last beat).
            buf_d   = value_i;
            count_d = n_in;
            idx_d   = '0;
            value_d = value_i[0];
            valid_d = 1'b1;
            last_d  = (n_in == CntW'(1));
        end else if (xfer && !last_o) begin
            idx_d   = idx_inc;
            value_d = buf_q[idx_inc];
            last_d  = (CntW'(idx_inc) == (count_q - CntW'(1)));
        end else if (xfer) begin
            idx_d   = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q   <= '0;
            count_q <= '0;
            buf_q   <= '0;
            value_o <= '0;
            valid_o <= 1'b0;
            last_o  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            count_q <= count_d;
            buf_q   <= buf_d;
            value_o <= value_d;
            valid_o <= valid_d;
            last_o  <= last_d;
        end
    end

endmodule

// File: tb/tb_activation_serializer.sv
// Self-checking bench for activation_serializer: scripted scenarios with a
// queue of expected {last, value} beats pushed at load time.
module tb_activation_serializer;

    localparam int unsigned Bits  = 16;
    localparam int unsigned Lanes = 8;

    typedef struct packed {
        logic            l;
        logic [Bits-1:0] v;
    } beat_t;

    typedef logic [Lanes-1:0][Bits-1:0] vec_t;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic                 load_i;
    vec_t                 value_i;
    logic [11:0]          active_count_i;
    logic                 ready_o;
    logic signed [Bits-1:0] value_o;
    logic                 valid_o;
    logic                 last_o;
    logic                 ready_i;
    logic                 busy_o;

    int    vectors     = 0;
    int    miscompares = 0;
    beat_t sb[$];
    vec_t  va;
    vec_t  vb;
    vec_t  vc;

    activation_serializer #(
        .Bits        (Bits),
        .EngineCount (12'd8)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .load_i         (load_i),
        .value_i        (value_i),
        .active_count_i (active_count_i),
        .ready_o        (ready_o),
        .value_o        (value_o),
        .valid_o        (valid_o),
        .last_o         (last_o),
        .ready_i        (ready_i),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Push the expected beats of a vector (bench-side clamp to Lanes).
    task automatic push_vec(input vec_t v, input logic [11:0] n);
        int m;
        m = (n > 12'(Lanes)) ? Lanes : int'(n);
        for (int i = 0; i < m; i++) begin
            sb.push_back('{l: (i == m - 1), v: v[i]});
        end
    endtask

    function automatic beat_t front();
        beat_t b;
        b = '0;
        if (sb.size() != 0) b = sb[0];
        return b;
    endfunction

    // Drive a load at the next falling edge.
    task automatic drive_load(input vec_t v, input logic [11:0] n, input logic r);
        @(negedge clk_i);
        load_i = 1'b1;
        value_i = v;
        active_count_i = n;
        ready_i = r;
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        load_i = 1'b0;
        ready_i = 1'b0;
        value_i = '0;
        active_count_i = '0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", valid_o); end
        vectors++; if (last_o !== 1'b0) begin miscompares++; $display("FAIL reset_last got %b want 0", last_o); end
        vectors++; if (value_o !== 16'sd0) begin miscompares++; $display("FAIL reset_value got %h want 0", value_o); end
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy_o); end
        vectors++; if (ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", ready_o); end
    endtask

    // n=8, ready_i high: eight consecutive beats; inputs change after accept.
    task automatic test_full_stream();
        beat_t e;
        drive_load(va, 12'd8, 1'b1);
        vectors++; if (ready_o !== 1'b1) begin miscompares++; $display("FAIL full_ready_idle got %b want 1", ready_o); end
        push_vec(va, 12'd8);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_i);
            load_i = 1'b0;
            value_i = vb;
            active_count_i = 12'd1;
            ready_i = 1'b1;
            #1;
            e = front();
            vectors++; if (valid_o !== 1'b1) begin miscompares++; $display("FAIL full_valid beat %0d got %b want 1", c, valid_o); end
            vectors++; if ({last_o, value_o} !== e) begin miscompares++; $display("FAIL full_beat %0d got %b/%h want %b/%h", c, last_o, value_o, e.l, e.v); end
            vectors++; if (ready_o !== e.l) begin miscompares++; $display("FAIL full_ready beat %0d got %b want %b", c, ready_o, e.l); end
            vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL full_busy beat %0d got %b want 1", c, busy_o); end
            if (sb.size() != 0) void'(sb.pop_front());
        end
        @(negedge clk_i);
        #1;
        vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL full_end_valid got %b want 0", valid_o); end
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL full_end_busy got %b want 0", busy_o); end
    endtask

    // n=3 with stalls: value/last must hold while ready_i is low.
    task automatic test_stall();
        logic r;
        logic [5:0] pat;
        beat_t e;
        pat = 6'b110100;
        drive_load(va, 12'd3, 1'b0);
        push_vec(va, 12'd3);
        for (int c = 0; c < 6; c++) begin
            r = pat[c];
            @(negedge clk_i);
            load_i = 1'b0;
            ready_i = r;
            #1;
            e = front();
            vectors++; if (valid_o !== 1'b1) begin miscompares++; $display("FAIL stall_valid cyc %0d got %b want 1", c, valid_o); end
            vectors++; if ({last_o, value_o} !== e) begin miscompares++; $display("FAIL stall_beat cyc %0d got %b/%h want %b/%h", c, last_o, value_o, e.l, e.v); end
            vectors++; if (ready_o !== (r & e.l)) begin miscompares++; $display("FAIL stall_ready cyc %0d got %b want %b", c, ready_o, r & e.l); end
            if (r && sb.size() != 0) void'(sb.pop_front());
        end
        @(negedge clk_i);
        ready_i = 1'b1;
        #1;
        vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL stall_end_valid got %b want 0", valid_o); end
        vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL stall_pending got %0d want 0", sb.size()); end
    endtask

    // Second load in the last-beat cycle streams with no gap.
    task automatic test_back_to_back();
        beat_t e;
        drive_load(va, 12'd3, 1'b1);
        push_vec(va, 12'd3);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            ready_i = 1'b1;
            load_i = (c == 2);
            value_i = vc;
            active_count_i = 12'd2;
            #1;
            e = front();
            vectors++; if (valid_o !== 1'b1) begin miscompares++; $display("FAIL b2b_valid cyc %0d got %b want 1", c, valid_o); end
            vectors++; if ({last_o, value_o} !== e) begin miscompares++; $display("FAIL b2b_beat cyc %0d got %b/%h want %b/%h", c, last_o, value_o, e.l, e.v); end
            vectors++; if (ready_o !== e.l) begin miscompares++; $display("FAIL b2b_ready cyc %0d got %b want %b", c, ready_o, e.l); end
            if (sb.size() != 0) void'(sb.pop_front());
            if (c == 2) push_vec(vc, 12'd2);
        end
        @(negedge clk_i);
        load_i = 1'b0;
        #1;
        vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL b2b_end_valid got %b want 0", valid_o); end
    endtask

    // A load while ready_o is low must be ignored.
    task automatic test_ignore_load();
        beat_t e;
        drive_load(va, 12'd4, 1'b1);
        push_vec(va, 12'd4);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            ready_i = 1'b1;
            load_i = (c == 1);
            value_i = vb;
            active_count_i = 12'd8;
            #1;
            e = front();
            if (c == 1) begin
                vectors++; if (ready_o !== 1'b0) begin miscompares++; $display("FAIL ign_ready got %b want 0", ready_o); end
            end
            vectors++; if (valid_o !== 1'b1) begin miscompares++; $display("FAIL ign_valid cyc %0d got %b want 1", c, valid_o); end
            vectors++; if ({last_o, value_o} !== e) begin miscompares++; $display("FAIL ign_beat cyc %0d got %b/%h want %b/%h", c, last_o, value_o, e.l, e.v); end
            if (sb.size() != 0) void'(sb.pop_front());
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            load_i = 1'b0;
            #1;
            vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL ign_extra cyc %0d got %b want 0", c, valid_o); end
        end
    endtask

    // n=0 is discarded; n=4095 clamps to eight beats.
    task automatic test_count_bounds();
        int beats;
        beat_t e;
        drive_load(va, 12'd0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            load_i = 1'b0;
            #1;
            vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL n0_valid cyc %0d got %b want 0", c, valid_o); end
            vectors++; if (ready_o !== 1'b1) begin miscompares++; $display("FAIL n0_ready cyc %0d got %b want 1", c, ready_o); end
            vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL n0_busy cyc %0d got %b want 0", c, busy_o); end
        end
        drive_load(vb, 12'd4095, 1'b1);
        push_vec(vb, 12'd4095);
        beats = 0;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk_i);
            load_i = 1'b0;
            #1;
            if (valid_o === 1'b1) begin
                beats++;
                e = front();
                vectors++; if (sb.size() == 0 || {last_o, value_o} !== e) begin miscompares++; $display("FAIL nmax_beat cyc %0d got %b/%h want %b/%h", c, last_o, value_o, e.l, e.v); end
                if (sb.size() != 0) void'(sb.pop_front());
            end
        end
        vectors++; if (beats != 8) begin miscompares++; $display("FAIL nmax_count got %0d want 8", beats); end
    endtask

    // Reset during beat 3 drops the vector at once; then a single-beat vector.
    task automatic test_reset_mid();
        beat_t e;
        drive_load(vb, 12'd8, 1'b1);
        push_vec(vb, 12'd8);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            load_i = 1'b0;
            #1;
            e = front();
            vectors++; if ({last_o, value_o} !== e) begin miscompares++; $display("FAIL rmid_beat cyc %0d got %b/%h want %b/%h", c, last_o, value_o, e.l, e.v); end
            if (c < 2 && sb.size() != 0) void'(sb.pop_front());
        end
        rst_ni = 1'b0;
        #1;
        sb.delete();
        vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL rmid_valid got %b want 0", valid_o); end
        vectors++; if (last_o !== 1'b0) begin miscompares++; $display("FAIL rmid_last got %b want 0", last_o); end
        vectors++; if (value_o !== 16'sd0) begin miscompares++; $display("FAIL rmid_value got %h want 0", value_o); end
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL rmid_busy got %b want 0", busy_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        drive_load(vc, 12'd1, 1'b1);
        vectors++; if (ready_o !== 1'b1) begin miscompares++; $display("FAIL rmid_ready got %b want 1", ready_o); end
        push_vec(vc, 12'd1);
        @(negedge clk_i);
        load_i = 1'b0;
        #1;
        e = front();
        vectors++; if (valid_o !== 1'b1) begin miscompares++; $display("FAIL rmid_new_valid got %b want 1", valid_o); end
        vectors++; if ({last_o, value_o} !== e) begin miscompares++; $display("FAIL rmid_new_beat got %b/%h want %b/%h", last_o, value_o, e.l, e.v); end
        if (sb.size() != 0) void'(sb.pop_front());
        @(negedge clk_i);
        #1;
        vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL rmid_new_end got %b want 0", valid_o); end
    endtask

    initial begin
        va[0] = 16'hFFFD; va[1] = 16'h0005; va[2] = 16'h0000; va[3] = 16'hFF80;
        va[4] = 16'h007F; va[5] = 16'h0001; va[6] = 16'hFFFF; va[7] = 16'h002A;
        for (int i = 0; i < Lanes; i++) begin
            vb[i] = 16'(1000 + i);
            vc[i] = 16'(10 * (i + 1));
        end
        test_reset();
        test_full_stream();
        test_stall();
        test_back_to_back();
        test_ignore_load();
        test_count_bounds();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
